// File: rtl/pipelined_cla_addsub.sv
// Pipelined carry-lookahead adder/subtractor: one SEG-bit segment per stage,
// registered inter-segment carry, valid/ready flow control and ALU flags.
module pipelined_cla_addsub #(
  parameter int WIDTH = 32,
  parameter int SEG   = 16,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_co,
  output logic             out_ovf,
  output logic             out_zero,
  output logic             out_neg,
  output logic [TAG_W-1:0] out_tag
);

  localparam int N  = WIDTH / SEG;
  localparam int G  = SEG / 4;
  localparam int NB = (G + 3) / 4;
  localparam int NS = (N > 1) ? N - 1 : 1;

  function automatic logic [4:0] carry4(input logic [3:0] gv, input logic [3:0] pv,
                                        input logic cin);
    logic [4:0] c;
    c[0] = cin;
    c[1] = gv[0] | (pv[0] & cin);
    c[2] = gv[1] | (pv[1] & gv[0]) | (pv[1] & pv[0] & cin);
    c[3] = gv[2] | (pv[2] & gv[1]) | (pv[2] & pv[1] & gv[0]) | (pv[2] & pv[1] & pv[0] & cin);
    c[4] = gv[3] | (pv[3] & gv[2]) | (pv[3] & pv[2] & gv[1]) | (pv[3] & pv[2] & pv[1] & gv[0])
         | (&pv & cin);
    return c;
  endfunction

  // Bits -> 4-bit groups -> blocks of 4 groups, each level a flat lookahead; returns {cout, sum}.
  function automatic logic [SEG:0] cla_seg(input logic [SEG-1:0] a, input logic [SEG-1:0] b,
                                           input logic cin);
    logic [SEG-1:0]  p, g, c;
    logic [4*NB-1:0] gg, gp, gcar;
    logic [NB-1:0]   bg, bp;
    logic [NB:0]     bc;
    logic [4:0]      t;
    logic            r, term;
    p  = a ^ b;
    g  = a & b;
    gg = '0;
    gp = '1;
    for (int i = 0; i < G; i++) begin
      t     = carry4(g[4*i +: 4], p[4*i +: 4], 1'b0);
      gg[i] = t[4];
      gp[i] = &p[4*i +: 4];
    end
    for (int blk = 0; blk < NB; blk++) begin
      t       = carry4(gg[4*blk +: 4], gp[4*blk +: 4], 1'b0);
      bg[blk] = t[4];
      bp[blk] = &gp[4*blk +: 4];
    end
    for (int j = 0; j <= NB; j++) begin
      r = cin;
      for (int m = 0; m < j; m++) r = r & bp[m];
      for (int m = 0; m < j; m++) begin
        term = bg[m];
        for (int q = m + 1; q < j; q++) term = term & bp[q];
        r = r | term;
      end
      bc[j] = r;
    end
    for (int blk = 0; blk < NB; blk++) begin
      t                 = carry4(gg[4*blk +: 4], gp[4*blk +: 4], bc[blk]);
      gcar[4*blk +: 4]  = t[3:0];
    end
    for (int i = 0; i < G; i++) begin
      t            = carry4(g[4*i +: 4], p[4*i +: 4], gcar[i]);
      c[4*i +: 4]  = t[3:0];
    end
    return {bc[NB], p ^ c};
  endfunction

  logic [WIDTH-1:0] a_q [NS];
  logic [WIDTH-1:0] b_q [NS];
  logic [WIDTH-1:0] sum_q [NS];
  logic             carry_q [NS];
  logic [TAG_W-1:0] tag_q [NS];
  logic [N-1:0]     v_q, v_d;
  logic [WIDTH-1:0] out_sum_q;
  logic [TAG_W-1:0] out_tag_q;
  logic             co_q, ovf_q, zero_q, neg_q;

  logic [WIDTH-1:0] a_d [N];
  logic [WIDTH-1:0] b_d [N];
  logic [WIDTH-1:0] sum_d [N];
  logic             carry_d [N];
  logic             cin_d [N];
  logic [TAG_W-1:0] tag_d [N];
  logic [SEG:0]     seg_res [N];
  logic             advance, accept, co_d, ovf_d, zero_d, neg_d;

  always_comb begin
    advance = !v_q[N-1] || out_ready;
    accept  = in_valid && advance && !flush;
    v_d     = v_q;
    v_d[0]  = accept;
    for (int k = 1; k < N; k++) v_d[k] = v_q[k-1];

    a_d[0]   = in_a;
    b_d[0]   = in_b ^ {WIDTH{in_sub}};
    cin_d[0] = in_sub;
    sum_d[0] = '0;
    tag_d[0] = in_tag;
    for (int k = 1; k < N; k++) begin
      a_d[k]   = a_q[k-1];
      b_d[k]   = b_q[k-1];
      cin_d[k] = carry_q[k-1];
      sum_d[k] = sum_q[k-1];
      tag_d[k] = tag_q[k-1];
    end
    // Each stage fills in its own slice; lower slices ride along already resolved.
    for (int k = 0; k < N; k++) begin
      seg_res[k]               = cla_seg(a_d[k][k*SEG +: SEG], b_d[k][k*SEG +: SEG], cin_d[k]);
      sum_d[k][k*SEG +: SEG]   = seg_res[k][SEG-1:0];
      carry_d[k]               = seg_res[k][SEG];
    end

    co_d   = carry_d[N-1];
    ovf_d  = (a_d[N-1][WIDTH-1] ~^ b_d[N-1][WIDTH-1]) & (a_d[N-1][WIDTH-1] ^ sum_d[N-1][WIDTH-1]);
    zero_d = ~|sum_d[N-1];
    neg_d  = sum_d[N-1][WIDTH-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q       <= '0;
      out_sum_q <= '0;
      out_tag_q <= '0;
      co_q      <= 1'b0;
      ovf_q     <= 1'b0;
      zero_q    <= 1'b0;
      neg_q     <= 1'b0;
      for (int k = 0; k < NS; k++) begin
        a_q[k]     <= '0;
        b_q[k]     <= '0;
        sum_q[k]   <= '0;
        carry_q[k] <= 1'b0;
        tag_q[k]   <= '0;
      end
    end else begin
      if (flush)        v_q <= '0;
      else if (advance) v_q <= v_d;
      if (advance) begin
        for (int k = 0; k < N - 1; k++) begin
          a_q[k]     <= a_d[k];
          b_q[k]     <= b_d[k];
          sum_q[k]   <= sum_d[k];
          carry_q[k] <= carry_d[k];
          tag_q[k]   <= tag_d[k];
        end
        out_sum_q <= sum_d[N-1];
        out_tag_q <= tag_d[N-1];
        co_q      <= co_d;
        ovf_q     <= ovf_d;
        zero_q    <= zero_d;
        neg_q     <= neg_d;
      end
    end
  end

  assign in_ready  = advance && !flush;
  assign out_valid = v_q[N-1];
  assign out_sum   = out_sum_q;
  assign out_tag   = out_tag_q;
  assign out_co    = co_q;
  assign out_ovf   = ovf_q;
  assign out_zero  = zero_q;
  assign out_neg   = neg_q;

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Self-checking bench for pipelined_cla_addsub: directed vector table and flow-control
// sequences on a 32/16 instance, random sweeps on 64/16 and 32/32 instances.
module tb_pipelined_cla_addsub;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] sum;
    logic        co, ovf, zero, neg;
  } vec_t;

  typedef struct {
    logic [31:0] sum;
    logic        co, ovf, zero, neg;
    logic [4:0]  tag;
    int          acc;
    bit          lat;
  } exp_t;

  typedef struct {
    logic [63:0] sum;
    logic        co, ovf, zero, neg;
    logic [4:0]  tag;
  } res_t;

  localparam int NRAND = 10000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Main 32/16 instance
  logic        flush, in_valid, in_ready, in_sub, out_valid, out_ready;
  logic        out_co, out_ovf, out_zero, out_neg;
  logic [31:0] in_a, in_b, out_sum;
  logic [4:0]  in_tag, out_tag;

  pipelined_cla_addsub #(.WIDTH(32), .SEG(16), .TAG_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_co(out_co), .out_ovf(out_ovf),
    .out_zero(out_zero), .out_neg(out_neg), .out_tag(out_tag));

  // 64/16 instance (latency 4)
  logic        r64_in_valid, r64_in_ready, r64_in_sub, r64_out_valid, r64_out_ready;
  logic        r64_co, r64_ovf, r64_zero, r64_neg;
  logic [63:0] r64_a, r64_b, r64_sum;
  logic [4:0]  r64_in_tag, r64_out_tag;
  logic        no_flush = 1'b0;

  pipelined_cla_addsub #(.WIDTH(64), .SEG(16), .TAG_W(5)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(no_flush), .in_valid(r64_in_valid), .in_ready(r64_in_ready),
    .in_a(r64_a), .in_b(r64_b), .in_sub(r64_in_sub), .in_tag(r64_in_tag),
    .out_valid(r64_out_valid), .out_ready(r64_out_ready), .out_sum(r64_sum), .out_co(r64_co),
    .out_ovf(r64_ovf), .out_zero(r64_zero), .out_neg(r64_neg), .out_tag(r64_out_tag));

  // 32/32 instance (latency 1)
  logic        r32_in_valid, r32_in_ready, r32_in_sub, r32_out_valid, r32_out_ready;
  logic        r32_co, r32_ovf, r32_zero, r32_neg;
  logic [31:0] r32_a, r32_b, r32_sum;
  logic [4:0]  r32_in_tag, r32_out_tag;

  pipelined_cla_addsub #(.WIDTH(32), .SEG(32), .TAG_W(5)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(no_flush), .in_valid(r32_in_valid), .in_ready(r32_in_ready),
    .in_a(r32_a), .in_b(r32_b), .in_sub(r32_in_sub), .in_tag(r32_in_tag),
    .out_valid(r32_out_valid), .out_ready(r32_out_ready), .out_sum(r32_sum), .out_co(r32_co),
    .out_ovf(r32_ovf), .out_zero(r32_zero), .out_neg(r32_neg), .out_tag(r32_out_tag));

  exp_t sb[$];
  res_t q64[$];
  res_t q32[$];

  // Reference: plain wide arithmetic, signed overflow by range check
  function automatic res_t model(input logic [63:0] a, input logic [63:0] b, input logic sub,
                                 input int w);
    res_t r;
    logic [63:0] mask, am, bm;
    logic [64:0] full;
    logic signed [65:0] sa, sbv, s, maxv, minv;
    mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    am = a & mask;
    bm = b & mask;
    if (sub) begin
      r.sum = (am - bm) & mask;
      r.co  = (am >= bm);
    end else begin
      full  = {1'b0, am} + {1'b0, bm};
      r.sum = full[63:0] & mask;
      r.co  = full[w];
    end
    sa   = (w == 64) ? $signed({{2{am[63]}}, am}) : $signed({{34{am[31]}}, am[31:0]});
    sbv  = (w == 64) ? $signed({{2{bm[63]}}, bm}) : $signed({{34{bm[31]}}, bm[31:0]});
    s    = sub ? (sa - sbv) : (sa + sbv);
    maxv = (66'sd1 <<< (w - 1)) - 66'sd1;
    minv = -(66'sd1 <<< (w - 1));
    r.ovf  = (s > maxv) || (s < minv);
    r.zero = (r.sum == 64'd0);
    r.neg  = r.sum[w-1];
    r.tag  = '0;
    return r;
  endfunction

  function automatic vec_t mkvec(input logic [31:0] a, input logic [31:0] b, input logic sub);
    vec_t v;
    res_t r;
    r = model({32'd0, a}, {32'd0, b}, sub, 32);
    v.a = a; v.b = b; v.sub = sub; v.sum = r.sum[31:0];
    v.co = r.co; v.ovf = r.ovf; v.zero = r.zero; v.neg = r.neg;
    return v;
  endfunction

  function automatic logic [63:0] pick64();
    case ($urandom_range(0, 7))
      0: return {64{1'b1}};
      1: return 64'd0;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'h7FFF_FFFF_FFFF_FFFF;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 7))
      0: return 32'hFFFF_FFFF;
      1: return 32'd0;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    checkVal($sformatf("sum tag%0d", e.tag), out_sum, e.sum);
    checkVal($sformatf("co tag%0d", e.tag), out_co, e.co);
    checkVal($sformatf("ovf tag%0d", e.tag), out_ovf, e.ovf);
    checkVal($sformatf("zero tag%0d", e.tag), out_zero, e.zero);
    checkVal($sformatf("neg tag%0d", e.tag), out_neg, e.neg);
    checkVal($sformatf("tag tag%0d", e.tag), out_tag, e.tag);
    if (e.lat) checkVal($sformatf("latency tag%0d", e.tag), cyc - e.acc, 2);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("[TB] FAIL unexpected_output: got tag %0d, expected none", out_tag);
      end else begin
        e = sb.pop_front();
        checkOutput(e);
      end
    end
  end

  always @(negedge clk) begin
    res_t e;
    if (rst_n && r64_out_valid && r64_out_ready) begin
      checks++;
      if (q64.size() == 0) begin
        errors++;
        $display("[TB] FAIL rand64_unexpected: got tag %0d, expected none", r64_out_tag);
      end else begin
        e = q64.pop_front();
        if ({r64_sum, r64_co, r64_ovf, r64_zero, r64_neg, r64_out_tag} !==
            {e.sum, e.co, e.ovf, e.zero, e.neg, e.tag}) begin
          errors++;
          $display("[TB] FAIL rand64: got sum=%h co=%b ovf=%b z=%b n=%b tag=%0d, expected sum=%h co=%b ovf=%b z=%b n=%b tag=%0d",
                   r64_sum, r64_co, r64_ovf, r64_zero, r64_neg, r64_out_tag,
                   e.sum, e.co, e.ovf, e.zero, e.neg, e.tag);
        end
      end
    end
  end

  always @(negedge clk) begin
    res_t e;
    if (rst_n && r32_out_valid && r32_out_ready) begin
      checks++;
      if (q32.size() == 0) begin
        errors++;
        $display("[TB] FAIL rand32_unexpected: got tag %0d, expected none", r32_out_tag);
      end else begin
        e = q32.pop_front();
        if ({r32_sum, r32_co, r32_ovf, r32_zero, r32_neg, r32_out_tag} !==
            {e.sum[31:0], e.co, e.ovf, e.zero, e.neg, e.tag}) begin
          errors++;
          $display("[TB] FAIL rand32: got sum=%h co=%b ovf=%b z=%b n=%b tag=%0d, expected sum=%h co=%b ovf=%b z=%b n=%b tag=%0d",
                   r32_sum, r32_co, r32_ovf, r32_zero, r32_neg, r32_out_tag,
                   e.sum[31:0], e.co, e.ovf, e.zero, e.neg, e.tag);
        end
      end
    end
  end

  // Presents one op until accepted (bounded); expectation is queued at the accept.
  task automatic applyStimulus(input vec_t v, input logic [4:0] tag, input bit lat);
    exp_t e;
    bit   done = 0;
    int   waitc = 0;
    in_a = v.a; in_b = v.b; in_sub = v.sub; in_tag = tag; in_valid = 1'b1;
    while (!done && waitc < 20) begin
      @(negedge clk);
      if (in_ready) begin
        e.sum = v.sum; e.co = v.co; e.ovf = v.ovf; e.zero = v.zero; e.neg = v.neg;
        e.tag = tag; e.acc = cyc; e.lat = lat;
        sb.push_back(e);
        done = 1;
      end
      @(posedge clk); #1;
      waitc++;
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("[TB] FAIL accept_timeout tag%0d: got no accept, expected accept", tag);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checkVal("drain_main", sb.size(), 0);
  endtask

  vec_t vecs[10];
  logic [31:0] snap_sum;
  logic [4:0]  snap_tag;

  initial begin
    int acc64, acc32, ncyc, n;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_sub = 1'b0; in_tag = '0;
    r64_in_valid = 1'b0; r64_out_ready = 1'b1; r64_a = '0; r64_b = '0; r64_in_sub = 1'b0; r64_in_tag = '0;
    r32_in_valid = 1'b0; r32_out_ready = 1'b1; r32_a = '0; r32_b = '0; r32_in_sub = 1'b0; r32_in_tag = '0;

    vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{32'h0000_0007, 32'h0000_0007, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 32'hACF1_3568, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[8] = '{32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[9] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1};

    // Reset state
    #3;
    checkVal("reset_out_valid", out_valid, 0);
    checkVal("reset_out_sum", out_sum, 0);
    checkVal("reset_out_tag", out_tag, 0);
    checkVal("reset_flags", {out_co, out_ovf, out_zero, out_neg}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    checkVal("reset_in_ready", in_ready, 1);

    // Directed vector table, back to back
    for (int i = 0; i < 10; i++) applyStimulus(vecs[i], 5'(i), 1'b1);
    drain();

    // Eight consecutive ops, tags 0..7
    for (int i = 0; i < 8; i++) applyStimulus(mkvec($urandom, $urandom, 1'(i & 1)), 5'(i), 1'b1);
    drain();

    // Output stall of three cycles in the middle of a stream
    fork
      begin
        for (int i = 0; i < 8; i++) applyStimulus(mkvec($urandom, $urandom, 1'(i & 1)), 5'(16 + i), 1'b0);
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          @(negedge clk);
          checkVal("stall_in_ready", in_ready, 0);
          checkVal("stall_out_valid", out_valid, 1);
          if (s == 0) begin
            snap_sum = out_sum;
            snap_tag = out_tag;
          end else begin
            checkVal("stall_hold_sum", out_sum, snap_sum);
            checkVal("stall_hold_tag", out_tag, snap_tag);
          end
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Flush with two ops in flight
    out_ready = 1'b0;
    applyStimulus(mkvec(32'h1111_1111, 32'h2222_2222, 1'b0), 5'd24, 1'b0);
    applyStimulus(mkvec(32'h3333_3333, 32'h1111_1111, 1'b1), 5'd25, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    checkVal("flush_in_ready", in_ready, 0);
    sb.delete();
    @(posedge clk);
    #1 flush = 1'b0;
    checkVal("flush_out_valid", out_valid, 0);
    out_ready = 1'b1;
    applyStimulus(mkvec(32'hDEAD_BEEF, 32'h0000_0011, 1'b0), 5'd26, 1'b1);
    drain();

    // Asynchronous reset mid-stream
    applyStimulus(mkvec(32'h0000_0100, 32'h0000_0200, 1'b0), 5'd27, 1'b0);
    applyStimulus(mkvec(32'h0000_0300, 32'h0000_0100, 1'b1), 5'd28, 1'b0);
    #2 rst_n = 1'b0;
    sb.delete();
    #1;
    checkVal("midreset_out_valid", out_valid, 0);
    checkVal("midreset_out_sum", out_sum, 0);
    checkVal("midreset_out_tag", out_tag, 0);
    checkVal("midreset_flags", {out_co, out_ovf, out_zero, out_neg}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    checkVal("midreset_in_ready", in_ready, 1);
    applyStimulus(mkvec(32'hFFFF_0000, 32'h0001_0000, 1'b0), 5'd29, 1'b1);
    drain();

    // Random sweep on the 64/16 and 32/32 instances with random back-pressure
    acc64 = 0; acc32 = 0; ncyc = 0;
    while ((acc64 < NRAND || acc32 < NRAND) && ncyc < 40000) begin
      @(posedge clk); #1;
      r64_in_valid  = (acc64 < NRAND) && ($urandom_range(0, 9) != 0);
      r64_a = pick64(); r64_b = pick64(); r64_in_sub = 1'($urandom_range(0, 1));
      r64_in_tag = 5'($urandom_range(0, 31));
      r64_out_ready = ($urandom_range(0, 3) != 0);
      r32_in_valid  = (acc32 < NRAND) && ($urandom_range(0, 9) != 0);
      r32_a = pick32(); r32_b = pick32(); r32_in_sub = 1'($urandom_range(0, 1));
      r32_in_tag = 5'($urandom_range(0, 31));
      r32_out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (r64_in_valid && r64_in_ready) begin
        res_t r;
        r = model(r64_a, r64_b, r64_in_sub, 64);
        r.tag = r64_in_tag;
        q64.push_back(r);
        acc64++;
      end
      if (r32_in_valid && r32_in_ready) begin
        res_t r;
        r = model({32'd0, r32_a}, {32'd0, r32_b}, r32_in_sub, 32);
        r.tag = r32_in_tag;
        q32.push_back(r);
        acc32++;
      end
      ncyc++;
    end
    @(posedge clk); #1;
    r64_in_valid = 1'b0; r32_in_valid = 1'b0;
    r64_out_ready = 1'b1; r32_out_ready = 1'b1;
    n = 0;
    while ((q64.size() != 0 || q32.size() != 0) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checkVal("rand64_accepted", acc64, NRAND);
    checkVal("rand32_accepted", acc32, NRAND);
    checkVal("rand64_drain", q64.size(), 0);
    checkVal("rand32_drain", q32.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
